// File: rtl/zoom_controller.sv
// zoom_controller: edge-detects zoom/refresh requests, tracks the signed zoom
// level, and runs one enable/done datapath transaction per frame under a
// watchdog. The displayed framebuffer flips only when a frame completes.
module zoom_controller #(
   parameter int IMG_W_IN    = 160,
   parameter int IMG_H_IN    = 120,
   parameter int MAX_LEVEL   = 2,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ZOOM_IN,
   input  logic       ZOOM_OUT,
   input  logic       REFRESH,
   input  logic       METHOD_SEL,
   input  logic       PROC_DONE,
   output logic       PROC_ENABLE,
   output logic [1:0] ALGORITHM,
   output logic [9:0] IMG_WIDTH_OUT,
   output logic [8:0] IMG_HEIGHT_OUT,
   output logic [2:0] ZOOM_LEVEL,
   output logic       FB_SEL,
   output logic       BUSY,
   output logic       FRAME_READY,
   output logic       REJECT,
   output logic       TIMEOUT_ERR
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic signed [7:0] MAX_S    = 8'(MAX_LEVEL);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;
   localparam logic [1:0] S_ABORT   = 2'd3;

   // Algorithm code for a target level: identity copy at level 0.
   function automatic logic [1:0] alg_of(input logic signed [7:0] t, input logic ms);
      if (t > 0)      return {1'b0, ms};
      else if (t < 0) return {1'b1, ms};
      else            return 2'b00;
   endfunction

   function automatic logic [7:0] mag_of(input logic signed [7:0] t);
      return t[7] ? 8'(-t) : 8'(t);
   endfunction

   // Output width/height: shift source size by the level, truncating.
   function automatic logic [9:0] width_of(input logic signed [7:0] t);
      logic [9:0] w;
      w = 10'(IMG_W_IN);
      return t[7] ? (w >> mag_of(t)) : (w << mag_of(t));
   endfunction

   function automatic logic [8:0] height_of(input logic signed [7:0] t);
      logic [8:0] h;
      h = 9'(IMG_H_IN);
      return t[7] ? (h >> mag_of(t)) : (h << mag_of(t));
   endfunction

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prev_in_q, prev_in_d, prev_out_q, prev_out_d, prev_ref_q, prev_ref_d;
   logic [2:0]    tgt_q, tgt_d;
   logic [2:0]    lvl_q, lvl_d;
   logic          en_q, en_d, fb_q, fb_d, busy_q, busy_d;
   logic          ready_q, ready_d, rej_q, rej_d, to_err_q, to_err_d;
   logic [1:0]    alg_q, alg_d, c_alg_q, c_alg_d;
   logic [9:0]    w_q, w_d, c_w_q, c_w_d;
   logic [8:0]    h_q, h_d, c_h_q, c_h_d;

   logic              rise_in, rise_out, rise_ref, any_rise;
   logic [1:0]        n_rise;
   logic signed [7:0] lvl_ext, tgt_req;

   // Request decode, watchdog and frame sequencing.
   always_comb begin
      rise_in  = ZOOM_IN  & ~prev_in_q;
      rise_out = ZOOM_OUT & ~prev_out_q;
      rise_ref = REFRESH  & ~prev_ref_q;
      any_rise = rise_in | rise_out | rise_ref;
      n_rise   = {1'b0, rise_in} + {1'b0, rise_out} + {1'b0, rise_ref};
      lvl_ext  = {{5{lvl_q[2]}}, lvl_q};
      tgt_req  = lvl_ext + {7'd0, rise_in} - {7'd0, rise_out};

      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_in_d  = ZOOM_IN;
      prev_out_d = ZOOM_OUT;
      prev_ref_d = REFRESH;
      tgt_d      = tgt_q;
      lvl_d      = lvl_q;
      en_d       = en_q;
      fb_d       = fb_q;
      busy_d     = busy_q;
      alg_d      = alg_q;
      w_d        = w_q;
      h_d        = h_q;
      c_alg_d    = c_alg_q;
      c_w_d      = c_w_q;
      c_h_d      = c_h_q;
      ready_d    = 1'b0;
      rej_d      = 1'b0;
      to_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (n_rise == 2'd1) begin
               if ((tgt_req > MAX_S) || (tgt_req < -MAX_S)) begin
                  rej_d = 1'b1;
               end else begin
                  tgt_d   = tgt_req[2:0];
                  alg_d   = alg_of(tgt_req, METHOD_SEL);
                  w_d     = width_of(tgt_req);
                  h_d     = height_of(tgt_req);
                  cnt_d   = '0;
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
               end
            end else if (n_rise > 2'd1) begin
               rej_d = 1'b1;
            end
         end
         S_RUN: begin
            rej_d = any_rise;
            // done takes priority over a watchdog expiry on the same cycle
            if (PROC_DONE) begin
               en_d    = 1'b0;
               state_d = S_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               en_d     = 1'b0;
               to_err_d = 1'b1;
               alg_d    = c_alg_q;
               w_d      = c_w_q;
               h_d      = c_h_q;
               state_d  = S_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            rej_d = any_rise;
            if (!PROC_DONE) begin
               lvl_d   = tgt_q;
               fb_d    = ~fb_q;
               ready_d = 1'b1;
               c_alg_d = alg_q;
               c_w_d   = w_q;
               c_h_d   = h_q;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_ABORT: begin
            rej_d = any_rise;
            if (!PROC_DONE) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything at once.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         prev_in_q  <= 1'b0;
         prev_out_q <= 1'b0;
         prev_ref_q <= 1'b0;
         tgt_q      <= '0;
         lvl_q      <= '0;
         en_q       <= 1'b0;
         fb_q       <= 1'b0;
         busy_q     <= 1'b0;
         alg_q      <= 2'b00;
         w_q        <= 10'(IMG_W_IN);
         h_q        <= 9'(IMG_H_IN);
         c_alg_q    <= 2'b00;
         c_w_q      <= 10'(IMG_W_IN);
         c_h_q      <= 9'(IMG_H_IN);
         ready_q    <= 1'b0;
         rej_q      <= 1'b0;
         to_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_in_q  <= prev_in_d;
         prev_out_q <= prev_out_d;
         prev_ref_q <= prev_ref_d;
         tgt_q      <= tgt_d;
         lvl_q      <= lvl_d;
         en_q       <= en_d;
         fb_q       <= fb_d;
         busy_q     <= busy_d;
         alg_q      <= alg_d;
         w_q        <= w_d;
         h_q        <= h_d;
         c_alg_q    <= c_alg_d;
         c_w_q      <= c_w_d;
         c_h_q      <= c_h_d;
         ready_q    <= ready_d;
         rej_q      <= rej_d;
         to_err_q   <= to_err_d;
      end
   end

   assign PROC_ENABLE    = en_q;
   assign ALGORITHM      = alg_q;
   assign IMG_WIDTH_OUT  = w_q;
   assign IMG_HEIGHT_OUT = h_q;
   assign ZOOM_LEVEL     = lvl_q;
   assign FB_SEL         = fb_q;
   assign BUSY           = busy_q;
   assign FRAME_READY    = ready_q;
   assign REJECT         = rej_q;
   assign TIMEOUT_ERR    = to_err_q;

endmodule

// File: tb/tb_zoom_controller.sv
// Bench for zoom_controller: directed scenarios then random requests, with a
// transaction-level reference model and a bench-side datapath responder.
module tb_zoom_controller;

   localparam int W  = 160;
   localparam int H  = 120;
   localparam int ML = 2;
   localparam int TO = 16;

   logic       clk = 1'b0, rst = 1'b0;
   logic       zi = 1'b0, zo = 1'b0, rf = 1'b0, ms = 1'b0, dn = 1'b0;
   logic       en, fb, busy, ready, rej, to_err;
   logic [1:0] alg;
   logic [9:0] wout;
   logic [8:0] hout;
   logic [2:0] lvl;

   zoom_controller #(.IMG_W_IN(W), .IMG_H_IN(H), .MAX_LEVEL(ML), .TIMEOUT_CYC(TO)) dut (
      .CLK(clk), .RESET(rst), .ZOOM_IN(zi), .ZOOM_OUT(zo), .REFRESH(rf),
      .METHOD_SEL(ms), .PROC_DONE(dn), .PROC_ENABLE(en), .ALGORITHM(alg),
      .IMG_WIDTH_OUT(wout), .IMG_HEIGHT_OUT(hout), .ZOOM_LEVEL(lvl), .FB_SEL(fb),
      .BUSY(busy), .FRAME_READY(ready), .REJECT(rej), .TIMEOUT_ERR(to_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   // reference model: committed level/picture, plus the frame in flight
   int lvl_m, tgt_m, run_edges;
   bit fb_m, in_frame, enabled, ok_pending;
   bit p_zi, p_zo, p_rf;
   int e_alg, e_w, e_h, c_alg, c_w, c_h;
   bit e_ready, e_rej, e_to;

   // datapath responder: done after resp_delay enabled cycles (0 = never)
   int resp_delay = 5, resp_hold = 0, dp_cnt = 0, dp_hold = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int alg_for(input int t, input bit m);
      if (t == 0) return 0;
      return (t < 0 ? 2 : 0) + (m ? 1 : 0);
   endfunction

   function automatic int scale(input int base, input int t);
      if (t >= 0) return base * (2 ** t);
      return base / (2 ** (-t));
   endfunction

   task automatic model_reset();
      lvl_m = 0; tgt_m = 0; run_edges = 0; fb_m = 0;
      in_frame = 0; enabled = 0; ok_pending = 0;
      p_zi = 0; p_zo = 0; p_rf = 0;
      e_alg = 0; e_w = W; e_h = H; c_alg = 0; c_w = W; c_h = H;
      e_ready = 0; e_rej = 0; e_to = 0;
      dn = 0; dp_cnt = 0; dp_hold = 0;
   endtask

   // one clock edge of behaviour, using the inputs the DUT sampled
   task automatic model_step();
      bit ri, ro, rr;
      int nr, t;
      ri = zi && !p_zi; ro = zo && !p_zo; rr = rf && !p_rf;
      p_zi = zi; p_zo = zo; p_rf = rf;
      nr = int'(ri) + int'(ro) + int'(rr);
      e_ready = 0; e_rej = 0; e_to = 0;
      if (!in_frame) begin
         if (nr > 1) e_rej = 1;
         else if (nr == 1) begin
            t = lvl_m + (ri ? 1 : 0) - (ro ? 1 : 0);
            if (t > ML || t < -ML) e_rej = 1;
            else begin
               tgt_m = t; e_alg = alg_for(t, ms); e_w = scale(W, t); e_h = scale(H, t);
               in_frame = 1; enabled = 1; run_edges = 0;
            end
         end
      end else begin
         if (nr != 0) e_rej = 1;
         if (enabled) begin
            run_edges++;
            if (dn) begin enabled = 0; ok_pending = 1; end
            else if (run_edges == TO) begin
               enabled = 0; ok_pending = 0; e_to = 1;
               e_alg = c_alg; e_w = c_w; e_h = c_h;
            end
         end else if (!dn) begin
            in_frame = 0;
            if (ok_pending) begin
               lvl_m = tgt_m; fb_m = !fb_m; e_ready = 1;
               c_alg = e_alg; c_w = e_w; c_h = e_h;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("enable", en, enabled);
      chk("algorithm", alg, e_alg);
      chk("width", wout, e_w);
      chk("height", hout, e_h);
      chk("level", lvl, 32'(lvl_m[2:0]));
      chk("fb_sel", fb, fb_m);
      chk("busy", busy, in_frame);
      chk("frame_ready", ready, e_ready);
      chk("reject", rej, e_rej);
      chk("timeout_err", to_err, e_to);
   endtask

   task automatic responder();
      if (enabled) begin
         dp_cnt++;
         dn = (resp_delay != 0) && (dp_cnt >= resp_delay);
         dp_hold = resp_hold;
      end else begin
         dp_cnt = 0;
         if (dn) begin
            if (dp_hold == 0) dn = 0;
            else dp_hold--;
         end
      end
   endtask

   task automatic cyc(input bit a, input bit b, input bit c, input bit m);
      @(negedge clk);
      responder();
      zi = a; zo = b; rf = c; ms = m;
      @(posedge clk);
      model_step();
      #1 check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, ms);
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      model_reset();
      repeat (2) begin @(posedge clk); #1 check_all(); end
      @(negedge clk) rst = 1'b0;

      // zoom-in x2 with NN; ZOOM_IN held for 10 cycles gives one frame
      resp_delay = 5; resp_hold = 0;
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
      idle(6);

      // zoom out to -2 with BA, then a refused third step
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 0, 1);
         idle(10);
      end

      // simultaneous requests are refused
      cyc(1, 1, 0, 0);
      idle(2);

      // watchdog abort, then done exactly on the expiry cycle
      resp_delay = 0;
      cyc(1, 0, 0, 0);
      idle(TO + 3);
      resp_delay = TO;
      cyc(0, 0, 1, 1);
      idle(TO + 3);

      // request while busy is dropped; done held 3 cycles after enable drops
      resp_delay = 8; resp_hold = 3;
      cyc(1, 0, 0, 1);
      idle(2);
      cyc(1, 0, 0, 0);
      idle(14);

      // reset in the middle of a frame
      resp_delay = 0; resp_hold = 0;
      cyc(0, 1, 0, 0);
      idle(3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_enable", en, 0);
      chk("async_level", lvl, 0);
      chk("async_width", wout, W);
      model_reset();
      @(posedge clk); #1 check_all();
      @(negedge clk) rst = 1'b0;
      resp_delay = 3;
      cyc(1, 0, 0, 0);
      idle(8);

      // random requests against the model
      for (int i = 0; i < 2500; i++) begin
         if (!enabled && !dn) begin
            resp_delay = $urandom_range(0, TO + 2);
            resp_hold  = $urandom_range(0, 3);
         end
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
